// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared types and defaults for the frame buffer reader
package hdmi_pkg;

    localparam int FRAME_PIXELS_DEFAULT = 307200;
    localparam int LAT_CNT_W            = 3;

    typedef logic [19:0] pix_addr_t;
    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fb_state_t;

endpackage

// File: rtl/fb_latency_counter.sv
// rtl/fb_latency_counter.sv - loadable down-counter with zero flag for read latency
module fb_latency_counter
    import hdmi_pkg::*;
(
    input  logic                 system_clk,
    input  logic                 n_rst,
    input  logic                 load,
    input  logic [LAT_CNT_W-1:0] load_value,
    input  logic                 count_en,
    output logic                 zero
);

    logic [LAT_CNT_W-1:0] cnt_q;

    // Load wins over counting; counting saturates at zero so it never wraps.
    always_ff @(posedge system_clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (count_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/frame_buffer_reader.sv
// rtl/frame_buffer_reader.sv - pixel fetch from SRAM for the HDMI path; FB_TEST_PATTERN_EN replaces SRAM data with an address pattern
module frame_buffer_reader
    import hdmi_pkg::*;
#(
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int MEM_LATENCY  = 2
) (
    input  logic        system_clk,
    input  logic        n_rst,
    input  logic        read_request,
    input  logic [19:0] address_line,
    output logic [23:0] data_line,
    output logic        data_ready,
    output logic        frame_done,
    output logic [19:0] mem_addr,
    output logic        mem_read,
    input  logic        mem_busy,
    input  logic [31:0] mem_rdata,
    output logic        req_overrun
);

    // WAIT spends MEM_LATENCY cycles: count from MEM_LATENCY-1 down to zero.
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

    fb_state_t state_q, state_d;
    pix_addr_t addr_q;
    pixel_t    data_q;
    pixel_t    fill_pixel;
    logic      ovr_q;
    logic      in_range;
    logic      issue_go;
    logic      cnt_load;
    logic      cnt_en;
    logic      cnt_zero;
    logic      capture;
    logic      unused_ok;

    assign in_range = (32'(address_line) < FRAME_PIXELS);

`ifdef FB_TEST_PATTERN_EN
    // Pattern mode keeps the access timing but never touches the SRAM.
    assign issue_go   = 1'b1;
    assign fill_pixel = {3{addr_q[7:0]}};
    assign mem_read   = 1'b0;
    assign unused_ok  = ^{mem_rdata, mem_busy};
`else
    assign issue_go   = ~mem_busy;
    assign fill_pixel = mem_rdata[23:0];
    assign mem_read   = (state_q == ST_ISSUE);
    assign unused_ok  = ^mem_rdata[31:24];
`endif

    fb_latency_counter u_lat (
        .system_clk (system_clk),
        .n_rst      (n_rst),
        .load       (cnt_load),
        .load_value (LAT_LOAD),
        .count_en   (cnt_en),
        .zero       (cnt_zero)
    );

    // State register; reset abandons any in-flight access.
    always_ff @(posedge system_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (read_request) begin
                    state_d = in_range ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                if (issue_go) begin
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address is only taken in IDLE so late requests cannot disturb an access.
    always_ff @(posedge system_clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_q <= '0;
        end else if ((state_q == ST_IDLE) && read_request) begin
            addr_q <= address_line;
        end
    end

    // Pixel register: black for out-of-range requests, fetched pixel otherwise; holds between responses.
    always_ff @(posedge system_clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q <= '0;
        end else if ((state_q == ST_IDLE) && read_request && !in_range) begin
            data_q <= '0;
        end else if (capture) begin
            data_q <= fill_pixel;
        end
    end

    // Sticky overrun: any request seen while not in IDLE.
    always_ff @(posedge system_clk or negedge n_rst) begin
        if (!n_rst) begin
            ovr_q <= 1'b0;
        end else if (read_request && (state_q != ST_IDLE)) begin
            ovr_q <= 1'b1;
        end
    end

    assign data_line   = data_q;
    assign data_ready  = (state_q == ST_RESP);
    assign frame_done  = (state_q == ST_RESP) && (32'(addr_q) == (FRAME_PIXELS - 1));
    assign mem_addr    = (state_q == ST_ISSUE) ? addr_q : '0;
    assign req_overrun = ovr_q;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb/tb_frame_buffer_reader.sv - scoreboard bench for frame_buffer_reader
module tb_frame_buffer_reader;

    localparam int FP = 307200;
    localparam int ML = 2;

    logic        tb_sys_clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        read_request = 1'b0;
    logic [19:0] address_line = '0;
    logic [23:0] data_line;
    logic        data_ready;
    logic        frame_done;
    logic [19:0] mem_addr;
    logic        mem_read;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        req_overrun;

    always #5 tb_sys_clk = ~tb_sys_clk;

    frame_buffer_reader #(.FRAME_PIXELS(FP), .MEM_LATENCY(ML)) dut (
        .system_clk   (tb_sys_clk),
        .n_rst        (n_rst),
        .read_request (read_request),
        .address_line (address_line),
        .data_line    (data_line),
        .data_ready   (data_ready),
        .frame_done   (frame_done),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_busy     (mem_busy),
        .mem_rdata    (mem_rdata),
        .req_overrun  (req_overrun)
    );

    typedef struct {
        logic [23:0] data;
        logic        fd;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          accepts  = 0;
    logic [19:0] cur_addr = '0;
    bit          pend     = 1'b0;
    int          pend_due = 0;
    logic [31:0] pend_word = '0;
    logic        exp_ovr  = 1'b0;
    logic [23:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [19:0] a);
        logic [23:0] p;
        if (a == 20'd5) return 32'hFF123456;
        p = {4'h0, a} * 24'd40503;
        return {8'hC3, p ^ 24'h5A5A5A};
    endfunction

    function automatic logic [23:0] exp_pixel(input logic [19:0] a);
        logic [31:0] w;
        if (32'(a) >= FP) return 24'h000000;
`ifdef FB_TEST_PATTERN_EN
        return {a[7:0], a[7:0], a[7:0]};
`else
        w = mem_word(a);
        return w[23:0];
`endif
    endfunction

    function automatic int exp_latency(input logic [19:0] a, input int busy);
        if (32'(a) >= FP) return 1;
`ifdef FB_TEST_PATTERN_EN
        return ML + 2;
`else
        return ML + 2 + busy;
`endif
    endfunction

    always @(posedge tb_sys_clk) cyc++;

    // SRAM model and response monitor, both evaluated away from the active edge.
    always @(negedge tb_sys_clk) begin
        exp_t e;
        if (pend && (cyc == pend_due)) begin
            mem_rdata = pend_word;
            pend = 1'b0;
        end else begin
            mem_rdata = $urandom;
        end
        if (mem_read) begin
`ifdef FB_TEST_PATTERN_EN
            check("mem_read_in_pattern_mode", 32'(mem_read), 32'd0);
`endif
            check("mem_addr_during_issue", 32'(mem_addr), 32'(cur_addr));
            if (!mem_busy) begin
                accepts++;
                pend      = 1'b1;
                pend_due  = cyc + ML;
                pend_word = mem_word(mem_addr);
            end
        end
        if (data_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_data_ready: data_line %0h with no request outstanding (cycle %0d)", data_line, cyc);
            end else begin
                e = exp_q.pop_front();
                check("data_line", 32'(data_line), 32'(e.data));
                check("frame_done", 32'(frame_done), 32'(e.fd));
                check("response_cycle", cyc, e.due);
            end
        end else if (frame_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_without_ready: got 1 expected 0 (cycle %0d)", cyc);
        end
    end

    task automatic do_req(input logic [19:0] a, input int busy);
        exp_t e;
        @(posedge tb_sys_clk);
        #1;
        read_request = 1'b1;
        address_line = a;
        e.data = exp_pixel(a);
        e.fd   = (32'(a) == FP - 1);
        e.due  = cyc + exp_latency(a, busy);
        exp_q.push_back(e);
        last_data = e.data;
        if (32'(a) < FP) cur_addr = a;
        @(posedge tb_sys_clk);
        #1;
        read_request = 1'b0;
        address_line = 20'($urandom);
        if ((32'(a) < FP) && (busy > 0)) begin
            mem_busy = 1'b1;
            repeat (busy) @(posedge tb_sys_clk);
            #1;
            mem_busy = 1'b0;
        end
    endtask

    task automatic wait_resp();
        int t = 0;
        while ((exp_q.size() != 0) && (t < 60)) begin
            @(posedge tb_sys_clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL response_timeout: %0d responses outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
        check("data_line_hold", 32'(data_line), 32'(last_data));
        check("req_overrun", 32'(req_overrun), 32'(exp_ovr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_line"},   32'(data_line),   32'd0);
        check({tag, "_data_ready"},  32'(data_ready),  32'd0);
        check({tag, "_frame_done"},  32'(frame_done),  32'd0);
        check({tag, "_mem_read"},    32'(mem_read),    32'd0);
        check({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
        check({tag, "_req_overrun"}, 32'(req_overrun), 32'd0);
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        exp_q.delete();
        read_request = 1'b0;
        mem_busy = 1'b0;
        exp_ovr = 1'b0;
        last_data = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge tb_sys_clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        int acc0;
        logic [19:0] a;
        int r;
        #2;
        apply_reset();

        // Basic fetch, last pixel of frame, out-of-range, stalled SRAM, pattern address.
        do_req(20'd5, 0);
        wait_resp();
        do_req(20'(FP - 1), 0);
        wait_resp();
        acc0 = accepts;
        do_req(20'(FP), 0);
        wait_resp();
        check("no_access_out_of_range", accepts, acc0);
        do_req(20'h12345, 3);
        wait_resp();
        do_req(20'h000AB, 0);
        wait_resp();

        // Request arriving in the RESP cycle is ignored and flagged.
        acc0 = accepts;
        do_req(20'd77, 0);
        repeat (ML + 1) @(posedge tb_sys_clk);
        #1;
        read_request = 1'b1;
        address_line = 20'd99;
        exp_ovr = 1'b1;
        @(posedge tb_sys_clk);
        #1;
        read_request = 1'b0;
        wait_resp();
        repeat (6) @(posedge tb_sys_clk);
`ifndef FB_TEST_PATTERN_EN
        check("single_access_resp_overrun", accepts - acc0, 1);
`endif

        // Request arriving during WAIT is ignored and flagged.
        apply_reset();
        acc0 = accepts;
        do_req(20'd1000, 0);
        @(posedge tb_sys_clk);
        #1;
        read_request = 1'b1;
        address_line = 20'd2000;
        exp_ovr = 1'b1;
        @(posedge tb_sys_clk);
        #1;
        read_request = 1'b0;
        wait_resp();
        repeat (6) @(posedge tb_sys_clk);
`ifndef FB_TEST_PATTERN_EN
        check("single_access_wait_overrun", accepts - acc0, 1);
`endif

        // Reset during WAIT: outputs clear at once and no response follows.
        do_req(20'd3000, 0);
        @(posedge tb_sys_clk);
        #1;
        apply_reset();
        repeat (8) @(posedge tb_sys_clk);
        #1;
        check("no_resp_after_reset", 32'(data_line), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 20'(FP - 1);
            else if (r == 1) a = 20'(FP + int'($urandom_range(0, 1000)));
            else if (r == 2) a = 20'd0;
            else             a = 20'($urandom_range(0, FP - 1));
            do_req(a, int'($urandom_range(0, 3)));
            wait_resp();
            repeat ($urandom_range(0, 2)) @(posedge tb_sys_clk);
        end

        repeat (4) @(posedge tb_sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
